// File: rtl/hrd_arb_pkg.sv
// Shared constants and helpers for the HRD piece-data source arbiter.
package hrd_arb_pkg;

   localparam int N_SRC  = 6;
   localparam int SEL_W  = 3;
   localparam int DATA_W = 5;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CAPT = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   // Source index to one-hot request/grant vector.
   function automatic logic [N_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
      onehot = N_SRC'(1) << idx;
   endfunction

endpackage

// File: rtl/rr_pick6.sv
// Rotating-priority picker: first set request bit after 'last', wrapping 5->0.
module rr_pick6
   import hrd_arb_pkg::*;
(
   input  logic [N_SRC-1:0] req,
   input  logic [SEL_W-1:0] last,
   output logic [SEL_W-1:0] winner,
   output logic             found
);

   logic [SEL_W:0] cand;

   // Scan candidates last+1 .. last+N_SRC (mod N_SRC); the earliest set bit wins.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      cand   = '0;
      for (int k = 1; k <= N_SRC; k++) begin
         cand = {1'b0, last} + (SEL_W+1)'(k);
         if (cand >= (SEL_W+1)'(N_SRC))
            cand = cand - (SEL_W+1)'(N_SRC);
         if (!found && req[cand[SEL_W-1:0]]) begin
            found  = 1'b1;
            winner = cand[SEL_W-1:0];
         end
      end
   end

endmodule

// File: rtl/hrd_src_arbiter.sv
// Round-robin arbiter and capture controller for the 6-source piece-data mux.
// One transfer at a time: grant (sel/gnt), capture mux output, hold until accepted.
module hrd_src_arbiter
   import hrd_arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_SRC-1:0]  req,
   input  logic [DATA_W-1:0] din,
   output logic [SEL_W-1:0]  sel,
   output logic [N_SRC-1:0]  gnt,
   output logic [N_SRC-1:0]  ack,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready
);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [SEL_W-1:0] last;
   logic [SEL_W-1:0] pick;
   logic             found;
   logic             do_grant;
   logic             do_capt;
   logic             do_accept;

   rr_pick6 u_pick (
      .req    (req),
      .last   (last),
      .winner (pick),
      .found  (found)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic; the unused encoding falls back to IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (found) state_nxt = ST_CAPT;
         ST_CAPT: state_nxt = ST_HOLD;
         ST_HOLD: if (dout_valid && dout_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Per-state load strobes for the registered outputs.
   always_comb begin
      do_grant  = (state == ST_IDLE) && found;
      do_capt   = (state == ST_CAPT);
      do_accept = (state == ST_HOLD) && dout_valid && dout_ready;
   end

   // Output and arbitration-history registers. The mux has had a full cycle
   // on the registered sel by the time CAPT samples din. ack mirrors gnt for
   // the single cycle following capture.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sel        <= '0;
         gnt        <= '0;
         ack        <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         last       <= SEL_W'(N_SRC-1);
      end else begin
         ack <= do_capt ? gnt : '0;
         if (do_grant) begin
            sel <= pick;
            gnt <= onehot(pick);
         end
         if (do_capt) begin
            dout       <= din;
            dout_valid <= 1'b1;
         end
         if (do_accept) begin
            dout_valid <= 1'b0;
            gnt        <= '0;
            last       <= sel;
         end
      end
   end

endmodule

// File: tb/tb_hrd_src_arbiter.sv
// Testbench for hrd_src_arbiter: table-driven transfers, scoreboard on accepted data.
module tb_hrd_src_arbiter;
   import hrd_arb_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N_SRC-1:0]  req;
   logic [DATA_W-1:0] din;
   logic [SEL_W-1:0]  sel;
   logic [N_SRC-1:0]  gnt;
   logic [N_SRC-1:0]  ack;
   logic [DATA_W-1:0] dout;
   logic              dout_valid;
   logic              dout_ready;

   always #5 clk = ~clk;

   // Mux model: source s presents 5'h10 | s.
   assign din = {2'b10, sel};

   hrd_src_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .din        (din),
      .sel        (sel),
      .gnt        (gnt),
      .ack        (ack),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready)
   );

   typedef struct {
      logic [N_SRC-1:0] req;
      logic [SEL_W-1:0] src;
      int               stall;
   } vec_t;

   typedef struct {
      logic [SEL_W-1:0]  src;
      logic [DATA_W-1:0] data;
   } exp_t;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sbq[$];
   bit   skip_mon = 1'b0;
   logic pv = 1'b0;
   logic [DATA_W-1:0] pdout = '0;
   logic [SEL_W-1:0]  psel = '0;
   vec_t tbl[16];

   function automatic logic [DATA_W-1:0] mux_of(input logic [SEL_W-1:0] s);
      return {2'b10, s};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input logic [SEL_W-1:0] s);
      exp_t e;
      e.src  = s;
      e.data = mux_of(s);
      sbq.push_back(e);
   endtask

   // Scoreboard monitor: a completed transfer shows as dout_valid falling.
   always @(negedge clk) begin
      exp_t e;
      if (pv && !dout_valid && !skip_mon) begin
         if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_unexpected: got src %0d data %0h expected no transfer", psel, pdout);
         end else begin
            e = sbq.pop_front();
            chk("sb_src", 32'(psel), 32'(e.src));
            chk("sb_data", 32'(pdout), 32'(e.data));
         end
      end
      pv    = dout_valid;
      pdout = dout;
      psel  = sel;
   end

   // One complete transfer: grant, capture, optional stall, accept.
   task automatic xfer(input logic [N_SRC-1:0] r, input logic [SEL_W-1:0] s, input int stall);
      int waited;
      push_exp(s);
      req        = r;
      dout_ready = 1'b0;
      waited     = 0;
      @(negedge clk);
      while (gnt == '0 && waited < 8) begin
         @(negedge clk);
         waited++;
      end
      chk("grant_latency", 32'(waited), 32'd0);
      if (gnt == '0) return;
      chk("grant_sel", 32'(sel), 32'(s));
      chk("grant_onehot", 32'(gnt), 32'(onehot(s)));
      chk("grant_ack", 32'(ack), 32'd0);
      chk("grant_valid", 32'(dout_valid), 32'd0);
      @(negedge clk);
      chk("capt_ack", 32'(ack), 32'(onehot(s)));
      chk("capt_dout", 32'(dout), 32'(mux_of(s)));
      chk("capt_valid", 32'(dout_valid), 32'd1);
      chk("capt_gnt", 32'(gnt), 32'(onehot(s)));
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk("stall_ack", 32'(ack), 32'd0);
         chk("stall_dout", 32'(dout), 32'(mux_of(s)));
         chk("stall_sel", 32'(sel), 32'(s));
         chk("stall_gnt", 32'(gnt), 32'(onehot(s)));
         chk("stall_valid", 32'(dout_valid), 32'd1);
      end
      dout_ready = 1'b1;
      @(negedge clk);
      chk("acc_valid", 32'(dout_valid), 32'd0);
      chk("acc_gnt", 32'(gnt), 32'd0);
      chk("acc_ack", 32'(ack), 32'd0);
      chk("acc_sel", 32'(sel), 32'(s));
      dout_ready = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_sel"}, 32'(sel), 32'd0);
      chk({tag, "_gnt"}, 32'(gnt), 32'd0);
      chk({tag, "_ack"}, 32'(ack), 32'd0);
      chk({tag, "_dout"}, 32'(dout), 32'd0);
      chk({tag, "_valid"}, 32'(dout_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // {req, expected winner, ready stall cycles}; priority state carries over.
      tbl = '{
         '{6'h3F,     3'd0, 0},  // after reset source 0 first
         '{6'h3F,     3'd1, 0},
         '{6'h3F,     3'd2, 0},
         '{6'h3F,     3'd3, 0},
         '{6'h3F,     3'd4, 0},
         '{6'h3F,     3'd5, 0},
         '{6'h3F,     3'd0, 0},  // rotation wraps
         '{6'b001000, 3'd3, 0},  // single request, data 5'h13
         '{6'b010000, 3'd4, 0},  // sets last=4
         '{6'b100001, 3'd5, 0},  // wrap-around: 5 then 0
         '{6'b100001, 3'd0, 0},
         '{6'b100001, 3'd5, 0},
         '{6'h3F,     3'd0, 10}, // backpressure with all others requesting
         '{6'b000110, 3'd1, 0},
         '{6'b000110, 3'd2, 0},
         '{6'b000011, 3'd0, 0}   // search skips 3,4,5 and wraps
      };

      // Reset held for two edges with everything requesting.
      rst_n      = 1'b0;
      req        = 6'h3F;
      dout_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk_reset_vals("rst");

      // Idle with no requests: nothing moves.
      rst_n      = 1'b1;
      req        = '0;
      dout_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("idle_gnt", 32'(gnt), 32'd0);
         chk("idle_valid", 32'(dout_valid), 32'd0);
      end

      foreach (tbl[i]) xfer(tbl[i].req, tbl[i].src, tbl[i].stall);

      // Idle after a transfer: sel holds last winner, gnt stays zero.
      req = '0;
      repeat (3) begin
         @(negedge clk);
         chk("idle2_sel", 32'(sel), 32'd0);
         chk("idle2_gnt", 32'(gnt), 32'd0);
         chk("idle2_ack", 32'(ack), 32'd0);
      end

      // Capture is unconditional even when req drops during CAPT.
      push_exp(3'd4);
      req = 6'b010000;
      @(negedge clk);
      chk("drop_gnt", 32'(gnt), 32'(onehot(3'd4)));
      req = '0;
      @(negedge clk);
      chk("drop_valid", 32'(dout_valid), 32'd1);
      chk("drop_dout", 32'(dout), 32'(mux_of(3'd4)));
      chk("drop_ack", 32'(ack), 32'(onehot(3'd4)));
      dout_ready = 1'b1;
      @(negedge clk);
      chk("drop_acc", 32'(dout_valid), 32'd0);
      dout_ready = 1'b0;
      // last=4 now

      // Reset during HOLD discards the pending transfer.
      req = 6'b001000;
      @(negedge clk);
      chk("rh_gnt", 32'(gnt), 32'(onehot(3'd3)));
      @(negedge clk);
      chk("rh_valid", 32'(dout_valid), 32'd1);
      skip_mon = 1'b1;
      rst_n    = 1'b0;
      req      = 6'h3F;
      @(negedge clk);
      chk_reset_vals("rst_hold");
      rst_n = 1'b1;
      req   = '0;
      @(negedge clk);
      skip_mon = 1'b0;
      xfer(6'h3F, 3'd0, 0);  // arbitration restarts from source 0

      // Reset during CAPT: capture never happens.
      req = 6'b000100;
      @(negedge clk);
      chk("rc_gnt", 32'(gnt), 32'(onehot(3'd2)));
      rst_n = 1'b0;
      @(negedge clk);
      chk_reset_vals("rst_capt");
      rst_n = 1'b1;
      req   = '0;
      @(negedge clk);
      xfer(6'h3F, 3'd0, 0);

      repeat (2) @(negedge clk);
      chk("sb_drained", 32'(sbq.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hrd_src_arbiter.md
Name: hrd_src_arbiter

Overview:
Round-robin arbiter and capture controller for the shared 6-source, 5-bit piece-data mux in the Klotski (HRD) datapath. It drives the mux select from one of six requesters, such as board-cell updaters and move logic. It registers the mux output into a valid/ready channel toward the board/display consumer and acknowledges the served requester. One transfer at a time; each grant is held until the consumer accepts.

Parameters:
N_SRC, 6, number of requesters / mux data inputs in use
SEL_W, 3, mux select width
DATA_W, 5, mux data width

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  synchronous reset, active-low
req  in  N_SRC  per-source request; level, held until matching ack
din  in  DATA_W  mux output (combinational function of sel)
sel  out  SEL_W  registered mux select, to mux S input
gnt  out  N_SRC  registered one-hot grant; zero when idle
ack  out  N_SRC  one-cycle pulse to the served source on data capture
dout  out  DATA_W  registered captured data
dout_valid  out  1  dout holds an unaccepted transfer
dout_ready  in  1  consumer accepts dout when high with dout_valid

Behaviour:
- Reset (rst_n=0 at a clk edge, regardless of state): state=IDLE, sel=0, gnt=0, ack=0, dout=0, dout_valid=0, last=N_SRC-1 (source 0 has top priority after reset). Asynchronous rst_n changes have no effect until the next edge.
- State encoding is 2 bits: IDLE, CAPT, HOLD. Encoding 2'b11 is illegal and goes to IDLE.
- IDLE, no req: sel and gnt hold (gnt=0), no change.
- IDLE, req!=0: the winner is the first set bit searching from (last+1) mod N_SRC upward, wrapping 5->0. Registers sel<=winner and gnt<=onehot(winner), then goes to CAPT.
- CAPT: the mux has settled on the registered sel. Registers dout<=din, dout_valid<=1, ack<=onehot(winner) for exactly this edge's next cycle. Goes to HOLD.
  - Capture is unconditional even if req[winner] dropped.
- HOLD: dout and sel are stable. When dout_valid&&dout_ready:
  - dout_valid<=0, gnt<=0, last<=winner, then IDLE.
  - Otherwise stay; new requests are ignored.
- ack is high only in the first HOLD cycle; all other cycles ack=0.
- Latency: req seen in IDLE at edge k, sel/gnt valid after k, dout_valid after k+1, earliest accept at edge k+2, next grant at edge k+3. Maximum throughput is 1 transfer per 3 cycles.
- sel never takes values 6 or 7; it always equals the last winner, or 0 after reset.
- A req deasserted before being granted is dropped silently. A requester must deassert req within 1 cycle of its ack to avoid a re-grant.
- Simultaneous requests resolve by rotating priority only. Starvation is bounded at N_SRC-1 transfers.
- dout_ready while dout_valid=0 is ignored.

Decomposition:
- Package hrd_arb_pkg holds:
  - N_SRC, SEL_W, DATA_W constants
  - state localparams ST_IDLE=2'd0, ST_CAPT=2'd1, ST_HOLD=2'd2
- One combinational sub-module rr_pick6 (inputs req, last; outputs winner index and found flag). It is reused by any future resource arbiter in the game logic.
- The top contains the FSM, registers and output logic.

Test Plan:
- Reset: rst_n=0 for 2 edges with req=6'h3F, dout_ready=1 -> sel=0, gnt=0, ack=0, dout=0, dout_valid=0. After release, first grant goes to source 0.
- Single request: req=6'b001000, mux model returns 5'h13 for sel=3 -> sel=3, gnt=6'b001000 after 1 edge; ack[3] pulse and dout=5'h13, dout_valid=1 after 2 edges.
- Round-robin with all requesting: req=6'h3F held, dout_ready=1, each source dropping req after its ack and reasserting -> grant order 0,1,2,3,4,5,0, one every 3 cycles.
- Wrap-around: last=4, req=6'b100001 -> source 5 granted, then source 0.
- Backpressure: dout_ready=0 for 10 cycles in HOLD with other reqs high -> dout, sel and gnt unchanged, no ack, dout_valid=1. Transfer completes on the first ready cycle.
- Reset mid-operation: rst_n=0 for one edge during CAPT or HOLD -> all outputs at reset values on the next cycle. Any pending capture is discarded and arbitration restarts from source 0.
